// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: answers the card init sequence and CMD17
// single-block reads, streaming block bytes from an external memory port.
module sd_spi_responder #(
  parameter int unsigned ACMD41_BUSY = 2,
  parameter int unsigned READ_GAP    = 4,
  parameter logic [31:0] OCR         = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [40:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        init_done,
  output logic        cmd_strobe,
  output logic [5:0]  last_cmd,
  output logic [31:0] last_arg
);
  localparam int unsigned CNT_W    = 8;
  localparam logic [8:0]  LAST_IDX = 9'd511;

  typedef enum logic [2:0] {HUNT, CMD, NCR, RESP, GAP, TOKEN, DATA, CRC} state_t;
  state_t state, state_nxt;

  logic [1:0]       cs_sync, sclk_sync, mosi_sync;
  logic             sclk_d, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [37:0]      frame_sr;
  logic [5:0]       bit_cnt;
  logic [7:0]       tx_byte, load_val, hold;
  logic [2:0]       tx_bit, resp_cnt;
  logic [39:0]      resp_buf;
  logic [CNT_W-1:0] gap_cnt, busy_cnt;
  logic             crc_second, is_read, app_flag, mem_rd_d;
  logic [8:0]       data_idx;
  logic             byte_done, cmd_done;

  // Command decode, evaluated on the final bit of a frame
  logic [5:0]       f_cmd;
  logic [31:0]      f_arg, trail;
  logic [7:0]       r1;
  logic [2:0]       resp_len;
  logic             rd_cmd, init_nxt, app_nxt;
  logic [CNT_W-1:0] busy_nxt;

  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = !cs_s && sclk_sync[1] && !sclk_d;
  assign sclk_fall = !cs_s && !sclk_sync[1] && sclk_d;
  assign f_cmd     = frame_sr[37:32];
  assign f_arg     = frame_sr[31:0];
  assign cmd_done  = sclk_rise && (state == CMD) && (bit_cnt == 6'd47);
  assign byte_done = sclk_rise && (tx_bit == 3'd7) && (state != HUNT) && (state != CMD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b11;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  always_comb begin
    r1       = {7'd0, ~init_done};
    trail    = 32'd0;
    resp_len = 3'd1;
    rd_cmd   = 1'b0;
    init_nxt = init_done;
    app_nxt  = 1'b0;
    busy_nxt = busy_cnt;
    case (f_cmd)
      6'd0: begin
        r1       = 8'h01;
        init_nxt = 1'b0;
        busy_nxt = '0;
      end
      6'd8: begin
        trail    = {16'h0000, 8'h01, f_arg[7:0]};
        resp_len = 3'd5;
      end
      6'd55: app_nxt = 1'b1;
      6'd41: begin
        if (!app_flag) begin
          r1 = 8'h04 | {7'd0, ~init_done};
        end else if (init_done || busy_cnt >= CNT_W'(ACMD41_BUSY)) begin
          r1       = 8'h00;
          init_nxt = 1'b1;
        end else begin
          r1       = 8'h01;
          busy_nxt = busy_cnt + CNT_W'(1);
        end
      end
      6'd58: begin
        trail    = OCR;
        resp_len = 3'd5;
      end
      6'd16: r1 = {7'd0, ~init_done};
      6'd17: begin
        if (init_done) begin
          r1     = 8'h00;
          rd_cmd = 1'b1;
        end else begin
          r1 = 8'h05;
        end
      end
      default: r1 = 8'h04 | {7'd0, ~init_done};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // Next state and the byte to queue at each byte boundary
  always_comb begin
    state_nxt = state;
    load_val  = 8'hFF;
    if (cs_s) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:  if (sclk_rise && !mosi_s) state_nxt = CMD;
        CMD:   if (cmd_done) state_nxt = NCR;
        NCR: if (byte_done) begin
          state_nxt = RESP;
          load_val  = resp_buf[39:32];
        end
        RESP: if (byte_done) begin
          if (resp_cnt != 3'd0) begin
            load_val = resp_buf[39:32];
          end else if (!is_read) begin
            state_nxt = HUNT;
          end else if (READ_GAP == 0) begin
            state_nxt = TOKEN;
            load_val  = 8'hFE;
          end else begin
            state_nxt = GAP;
          end
        end
        GAP: if (byte_done && gap_cnt == '0) begin
          state_nxt = TOKEN;
          load_val  = 8'hFE;
        end
        TOKEN: if (byte_done) begin
          state_nxt = DATA;
          load_val  = hold;
        end
        DATA: if (byte_done) begin
          if (data_idx == LAST_IDX) begin
            state_nxt = CRC;
            load_val  = 8'h00;
          end else begin
            load_val = hold;
          end
        end
        CRC: if (byte_done) begin
          if (crc_second) state_nxt = HUNT;
          else            load_val  = 8'h00;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso       <= 1'b1;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_rd_d   <= 1'b0;
      init_done  <= 1'b0;
      cmd_strobe <= 1'b0;
      last_cmd   <= '0;
      last_arg   <= '0;
      frame_sr   <= '0;
      bit_cnt    <= '0;
      tx_byte    <= 8'hFF;
      tx_bit     <= '0;
      resp_buf   <= '0;
      resp_cnt   <= '0;
      gap_cnt    <= '0;
      busy_cnt   <= '0;
      crc_second <= 1'b0;
      is_read    <= 1'b0;
      app_flag   <= 1'b0;
      data_idx   <= '0;
      hold       <= '0;
    end else begin
      cmd_strobe <= cmd_done;
      mem_rd     <= 1'b0;
      mem_rd_d   <= mem_rd;
      if (mem_rd_d) hold <= mem_data;

      // miso idles high; otherwise it shifts out MSB first on sclk fall
      if (cs_s || state_nxt == HUNT || state_nxt == CMD) miso <= 1'b1;
      else if (sclk_fall) miso <= tx_byte[3'd7 - tx_bit];

      if (cs_s) begin
        bit_cnt <= '0;
        tx_bit  <= '0;
      end else begin
        if (sclk_rise && state == HUNT) bit_cnt <= mosi_s ? 6'd0 : 6'd1;
        if (sclk_rise && state == CMD) begin
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt >= 6'd2 && bit_cnt <= 6'd39) frame_sr <= {frame_sr[36:0], mosi_s};
        end
        if (sclk_rise && state != HUNT && state != CMD) tx_bit <= tx_bit + 3'd1;
        if (byte_done) tx_byte <= load_val;

        if (cmd_done) begin
          last_cmd  <= f_cmd;
          last_arg  <= f_arg;
          resp_buf  <= {r1, trail};
          resp_cnt  <= resp_len;
          is_read   <= rd_cmd;
          init_done <= init_nxt;
          app_flag  <= app_nxt;
          busy_cnt  <= busy_nxt;
          tx_byte   <= 8'hFF;
          tx_bit    <= '0;
        end

        if (byte_done) begin
          if (state == NCR || (state == RESP && resp_cnt != 3'd0)) begin
            resp_buf <= {resp_buf[31:0], 8'h00};
            resp_cnt <= resp_cnt - 3'd1;
          end
          if (state == RESP && state_nxt == GAP) gap_cnt <= CNT_W'(READ_GAP - 1);
          if (state == GAP) gap_cnt <= gap_cnt - CNT_W'(1);
          // Byte n is fetched while byte n-1 is on the wire
          if (state_nxt == TOKEN && state != TOKEN) begin
            mem_rd   <= 1'b1;
            mem_addr <= {last_arg, 9'd0};
          end
          if (state == TOKEN) begin
            data_idx      <= '0;
            mem_rd        <= 1'b1;
            mem_addr[8:0] <= 9'd1;
          end
          if (state == DATA && data_idx != LAST_IDX) begin
            data_idx <= data_idx + 9'd1;
            if (data_idx < 9'd510) begin
              mem_rd        <= 1'b1;
              mem_addr[8:0] <= data_idx + 9'd2;
            end
          end
          if (state == DATA) crc_second <= 1'b0;
          if (state == CRC)  crc_second <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD card emulator: the responder end of the SPI link that the SD controller drives as initiator.
- Sits on the bench/FPGA side of cs/sclk/mosi/miso, so the reader FSM and the tag-scan logic can be exercised without a physical card.
- Answers the init sequence and single-block reads (CMD17). Block data comes from an external byte-addressed memory port.

Parameters:
- ACMD41_BUSY, default 2: number of ACMD41 replies returning 0x01 before 0x00.
- READ_GAP, default 4: 0xFF bytes between CMD17 R1 and data token 0xFE.
- OCR, default 32'hC0FF8000: value returned by CMD58 (CCS=1, block addressing).

Ports:
- clk, input, 1: system clock; sclk must be ≤ clk/8.
- reset, input, 1: asynchronous, active-high.
- cs, input, 1: chip select from host, active-low.
- sclk, input, 1: SPI clock from host, mode 0.
- mosi, input, 1: host→card serial data.
- miso, output, 1: card→host serial data.
- mem_addr, output, 41: {block_addr[31:0], byte_idx[8:0]} for block data.
- mem_rd, output, 1: one-cycle read strobe.
- mem_data, input, 8: read data, valid exactly 1 clk after mem_rd.
- init_done, output, 1: ACMD41 returned 0x00.
- cmd_strobe, output, 1: one-cycle pulse when a full 48-bit command frame is received.
- last_cmd, output, 6: index of last command.
- last_arg, output, 32: argument of last command.

Behaviour:
- Reset values: miso=1, mem_rd=0, mem_addr=0, init_done=0, cmd_strobe=0, last_cmd=0, last_arg=0. Idle bit set, FSM=HUNT.
- cs, sclk and mosi pass through 2-FF synchronizers. sclk rise/fall are detected on the synchronized signal.
- mosi is sampled on sclk rise. miso changes on sclk fall, MSB first.
- miso=1 whenever cs is high or no byte is queued.
- States:
  - HUNT: cs low; bits shifted; the first 0 bit starts a frame. → CMD.
  - CMD: collect 48 bits. At bit 48, latch last_cmd=bits[45:40] and last_arg=bits[39:8], ignore CRC, pulse cmd_strobe. → NCR.
  - NCR: send one 0xFF byte. → RESP.
  - RESP: send R1, then any trailing bytes. → HUNT, or → GAP for a valid CMD17.
  - GAP: READ_GAP bytes of 0xFF. → TOKEN.
  - TOKEN: 0xFE. → DATA.
  - DATA: 512 bytes, byte_idx 0..511. → CRC.
  - CRC: 2 bytes 0x00. → HUNT.
- R1 bit0 = idle, i.e. !init_done.
- Command responses:
  - CMD0: R1=0x01; clears init_done and the ACMD41 counter.
  - CMD8: R1 followed by 00 00 01 arg[7:0].
  - CMD55: R1; arms the app flag for the next command only.
  - CMD41 with app flag: returns 0x01 ACMD41_BUSY times, then 0x00 and sets init_done; stays 0x00 thereafter.
  - CMD58: R1 followed by OCR, MSB first.
  - CMD16: R1.
  - CMD17 with init_done=1: R1=0x00, then the data phase with block_addr=last_arg.
  - CMD17 with init_done=0: R1=0x05 and no data phase.
  - Any other command, or CMD41 without CMD55: R1 = 0x04 | idle.
- Data prefetch:
  - mem_rd is pulsed with mem_addr of byte n while byte n-1 is shifting. The first prefetch is issued during TOKEN.
  - mem_data is captured in a holding register and loaded into the shifter on the byte boundary.
  - byte_idx saturates at 511; there is no wrap.
- mosi bits received during NCR..CRC are ignored; there is no CMD12 support.
- cs rising at any point aborts to HUNT within 3 clk and drives miso=1. Partial frame and shifter are discarded; init_done and the app flag are kept.
- cs falling re-enters HUNT at bit 0.
- Reset asserted mid-transfer forces all reset values immediately, asynchronously.
- An sclk edge coincident with a cs rise is ignored.

Test Plan:
- Reset, then cs low, send CMD0 (40 00 00 00 00 95) → cmd_strobe once, last_cmd=0, miso bytes FF, 01.
- CMD8 arg 0x000001AA → FF, 01, 00, 00, 01, AA. Then CMD55+CMD41 ×3 → R1 sequence 01, 01, 00 (CMD41 replies) and init_done=1 after the third.
- CMD17 arg 0x00002000 before init → R1=0x05, no 0xFE within 600 bytes. After init → FF, 00, 4×FF, FE, then 512 bytes equal to model memory at block 0x2000, idx 0..511, then 00 00. Check mem_addr[40:9]=0x2000 and exactly 512 mem_rd pulses.
- CMD58 after init → 00, C0, FF, 80, 00. CMD63 → R1=0x04.
- Deassert cs after data byte 100 of a CMD17 → miso=1 within 3 clk. Next CMD17 after cs low restarts at byte_idx 0.
- Assert reset during the CMD bit-collection phase → outputs at reset values, init_done=0, next CMD0 answered normally.
